// File: rtl/column_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : column_sweep_ctrl                                            |
// | Description : Sweeps one column of nodes bottom to top, feeding a          |
// |               combinational column_node and writing u_next/u_n back.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module column_sweep_ctrl #(
    parameter int ROWS   = 30,
    parameter int CENTER = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_wr,
    input  logic [8:0]  init_addr,
    input  logic [17:0] init_u_n,
    input  logic [17:0] init_u_prev,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [17:0] node_u_n,
    output logic [17:0] node_u_prev,
    output logic [17:0] node_u_up,
    output logic [17:0] node_u_down,
    input  logic [17:0] node_out,
    output logic [17:0] center_out
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PRIME = 4'd1;
    localparam logic [3:0] S_PW1   = 4'd2;
    localparam logic [3:0] S_PW2   = 4'd3;
    localparam logic [3:0] S_RD    = 4'd4;
    localparam logic [3:0] S_W1    = 4'd5;
    localparam logic [3:0] S_W2    = 4'd6;
    localparam logic [3:0] S_CALC  = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam logic [8:0] c_last_row = 9'(ROWS - 1);
    localparam logic [8:0] c_center   = 9'(CENTER);

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [8:0]  r_row;
    logic [17:0] r_cur;
    logic [17:0] r_prev;
    logic [17:0] r_up;
    logic [17:0] r_down;
    logic [17:0] r_center;

    logic [17:0] r_mem_un [0:511];
    logic [17:0] r_mem_up [0:511];

    logic        w_un_re;
    logic [8:0]  w_un_raddr;
    logic        w_up_re;
    logic [8:0]  w_up_raddr;
    logic        r_un_rv;
    logic        r_up_rv;
    logic [8:0]  r_un_raddr;
    logic [8:0]  r_up_raddr;
    logic [17:0] r_un_q;
    logic [17:0] r_up_q;

    logic        w_we;
    logic [8:0]  w_waddr;
    logic [17:0] w_un_wdata;
    logic [17:0] w_up_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        node_u_n     = 18'd0;
        node_u_prev  = 18'd0;
        node_u_up    = 18'd0;
        node_u_down  = 18'd0;
        w_un_re      = 1'b0;
        w_un_raddr   = 9'd0;
        w_up_re      = 1'b0;
        w_up_raddr   = 9'd0;
        w_we         = 1'b0;
        w_waddr      = 9'd0;
        w_un_wdata   = 18'd0;
        w_up_wdata   = 18'd0;
        case (r_state)
            S_IDLE: begin
                // Host write and start may coincide; the write lands first.
                if (init_wr) begin
                    w_we       = 1'b1;
                    w_waddr    = init_addr;
                    w_un_wdata = init_u_n;
                    w_up_wdata = init_u_prev;
                end
                if (start) begin
                    w_next_state = S_PRIME;
                end
            end
            S_PRIME: begin
                busy         = 1'b1;
                w_un_re      = 1'b1;
                w_next_state = S_PW1;
            end
            S_PW1: begin
                busy         = 1'b1;
                w_next_state = S_PW2;
            end
            S_PW2: begin
                busy         = 1'b1;
                w_next_state = S_RD;
            end
            S_RD: begin
                busy         = 1'b1;
                w_up_re      = 1'b1;
                w_up_raddr   = r_row;
                w_un_re      = (r_row != c_last_row);
                w_un_raddr   = r_row + 9'd1;
                w_next_state = S_W1;
            end
            S_W1: begin
                busy         = 1'b1;
                w_next_state = S_W2;
            end
            S_W2: begin
                busy         = 1'b1;
                w_next_state = S_CALC;
            end
            S_CALC: begin
                busy         = 1'b1;
                node_u_n     = r_cur;
                node_u_prev  = r_prev;
                node_u_up    = r_up;
                node_u_down  = r_down;
                w_we         = 1'b1;
                w_waddr      = r_row;
                w_un_wdata   = node_out;
                w_up_wdata   = r_cur;
                w_next_state = (r_row == c_last_row) ? S_DONE : S_RD;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we && !reset) begin
            r_mem_un[w_waddr] <= w_un_wdata;
            r_mem_up[w_waddr] <= w_up_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row      <= 9'd0;
            r_cur      <= 18'd0;
            r_prev     <= 18'd0;
            r_up       <= 18'd0;
            r_down     <= 18'd0;
            r_center   <= 18'd0;
            r_un_rv    <= 1'b0;
            r_up_rv    <= 1'b0;
            r_un_raddr <= 9'd0;
            r_up_raddr <= 9'd0;
            r_un_q     <= 18'd0;
            r_up_q     <= 18'd0;
        end else begin
            // Two-stage read: address register, then data register.
            r_un_rv <= w_un_re;
            r_up_rv <= w_up_re;
            if (w_un_re) begin
                r_un_raddr <= w_un_raddr;
            end
            if (w_up_re) begin
                r_up_raddr <= w_up_raddr;
            end
            if (r_un_rv) begin
                r_un_q <= r_mem_un[r_un_raddr];
            end
            if (r_up_rv) begin
                r_up_q <= r_mem_up[r_up_raddr];
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row <= 9'd0;
                    end
                end
                S_PW2: begin
                    r_cur  <= r_un_q;
                    r_down <= 18'd0;
                end
                S_W2: begin
                    r_prev <= r_up_q;
                    r_up   <= (r_row == c_last_row) ? 18'd0 : r_un_q;
                end
                S_CALC: begin
                    // down keeps the pre-update u_n of the row just written.
                    r_down <= r_cur;
                    r_cur  <= r_up;
                    if (r_row == c_center) begin
                        r_center <= node_out;
                    end
                    if (r_row != c_last_row) begin
                        r_row <= r_row + 9'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign center_out = r_center;

endmodule
`default_nettype wire

// File: tb/tb_column_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_column_sweep_ctrl                                         |
// | Description : Self-checking bench for column_sweep_ctrl with a stub node.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_column_sweep_ctrl;

    localparam int R       = 5;
    localparam int CTR     = 2;
    localparam int DONE_C  = 4 + 4 * R;
    localparam int N_VEC   = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_wr = 1'b0;
    logic [8:0]  init_addr = 9'd0;
    logic [17:0] init_u_n = 18'd0;
    logic [17:0] init_u_prev = 18'd0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [17:0] node_u_n;
    logic [17:0] node_u_prev;
    logic [17:0] node_u_up;
    logic [17:0] node_u_down;
    logic [17:0] node_out;
    logic [17:0] center_out;
    logic [1:0]  mode = 2'd0;

    always #5 clk = ~clk;

    column_sweep_ctrl #(.ROWS(R), .CENTER(CTR)) dut (
        .clk         (clk),
        .reset       (reset),
        .init_wr     (init_wr),
        .init_addr   (init_addr),
        .init_u_n    (init_u_n),
        .init_u_prev (init_u_prev),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .node_u_n    (node_u_n),
        .node_u_prev (node_u_prev),
        .node_u_up   (node_u_up),
        .node_u_down (node_u_down),
        .node_out    (node_out),
        .center_out  (center_out)
    );

    function automatic logic [17:0] node_fn(input logic [1:0] md, input logic [17:0] p,
                                            input logic [17:0] u, input logic [17:0] d);
        case (md)
            2'd0:    node_fn = u + d;
            2'd1:    node_fn = p;
            default: node_fn = u + d - p;
        endcase
    endfunction

    always_comb node_out = node_fn(mode, node_u_prev, node_u_up, node_u_down);

    typedef struct packed {
        logic [1:0]          mode;
        logic [R-1:0][17:0]  un;
        logic [R-1:0][17:0]  up;
        logic [R-1:0][17:0]  exp_new;
        logic [R-1:0][17:0]  exp_down;
        logic [17:0]         exp_center;
    } vec_t;

    vec_t vecs [N_VEC];

    int n_pass = 0;
    int n_total = 0;

    logic [17:0] m_un [R];
    logic [17:0] m_up [R];
    logic [17:0] e_n [R];
    logic [17:0] e_p [R];
    logic [17:0] e_u [R];
    logic [17:0] e_d [R];
    logic [17:0] m_center = 18'd0;
    logic [17:0] cap_n [R];
    logic [17:0] cap_p [R];
    logic [17:0] cap_u [R];
    logic [17:0] cap_d [R];

    task automatic check18(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_row(input int a, input logic [17:0] un, input logic [17:0] up);
        init_wr     = 1'b1;
        init_addr   = 9'(a);
        init_u_n    = un;
        init_u_prev = up;
        m_un[a]     = un;
        m_up[a]     = up;
        tick();
        init_wr = 1'b0;
    endtask

    // One time step of the column: every row sees old neighbours, then all rows update.
    task automatic model_step();
        logic [17:0] res [R];
        for (int i = 0; i < R; i++) begin
            e_n[i] = m_un[i];
            e_p[i] = m_up[i];
            e_u[i] = (i == R - 1) ? 18'd0 : m_un[i + 1];
            e_d[i] = (i == 0) ? 18'd0 : m_un[i - 1];
            res[i] = node_fn(mode, e_p[i], e_u[i], e_d[i]);
        end
        for (int i = 0; i < R; i++) begin
            m_up[i] = e_n[i];
            m_un[i] = res[i];
        end
        m_center = res[CTR];
    endtask

    // inj: 0 plain step, 1 stray start/init mid-sweep, 2 reset in CALC of abort_row.
    task automatic run_step(input int inj, input int abort_row, input bit with_init,
                            input logic [17:0] wi_un, input logic [17:0] wi_up);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        start = 1'b1;
        if (with_init) begin
            init_wr     = 1'b1;
            init_addr   = 9'(R - 1);
            init_u_n    = wi_un;
            init_u_prev = wi_up;
            m_un[R-1]   = wi_un;
            m_up[R-1]   = wi_up;
        end
        model_step();
        tick();
        start   = 1'b0;
        init_wr = 1'b0;
        for (int c = 1; c <= DONE_C + 1; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            for (int i = 0; i < R; i++) begin
                if (c == 7 + 4 * i) begin
                    cap_n[i] = node_u_n;
                    cap_p[i] = node_u_prev;
                    cap_u[i] = node_u_up;
                    cap_d[i] = node_u_down;
                end
            end
            if (inj == 1 && c == 5) begin
                start       = 1'b1;
                init_wr     = 1'b1;
                init_addr   = 9'd0;
                init_u_n    = 18'h00123;
                init_u_prev = 18'h00123;
            end
            if (inj == 1 && c == 6) begin
                start   = 1'b0;
                init_wr = 1'b0;
            end
            if (inj == 2 && c == 7 + 4 * abort_row) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                m_center = 18'd0;
                check_int("abort_busy", int'(busy), 0);
                check_int("abort_done", int'(done), 0);
                check18("abort_center", center_out, 18'd0);
                check18("abort_node_u_n", node_u_n, 18'd0);
                tick();
                check_int("abort_no_restart", int'(busy), 0);
                return;
            end
            tick();
        end
        check_int("busy_len", busy_cnt, 3 + 4 * R);
        check_int("done_count", done_cnt, 1);
        check_int("done_cycle", done_at, DONE_C);
        for (int i = 0; i < R; i++) begin
            check18($sformatf("row%0d_u_n", i), cap_n[i], e_n[i]);
            check18($sformatf("row%0d_u_prev", i), cap_p[i], e_p[i]);
            check18($sformatf("row%0d_up", i), cap_u[i], e_u[i]);
            check18($sformatf("row%0d_down", i), cap_d[i], e_d[i]);
        end
        check18("center_out", center_out, m_center);
    endtask

    task automatic init_random();
        for (int i = 0; i < R; i++) init_row(i, 18'($urandom), 18'($urandom));
    endtask

    initial begin
        vecs[0].mode       = 2'd0;
        vecs[0].un         = {18'd5, 18'd4, 18'd3, 18'd2, 18'd1};
        vecs[0].up         = '0;
        vecs[0].exp_new    = {18'd4, 18'd8, 18'd6, 18'd4, 18'd2};
        vecs[0].exp_down   = {18'd4, 18'd3, 18'd2, 18'd1, 18'd0};
        vecs[0].exp_center = 18'd6;

        vecs[1].mode       = 2'd1;
        vecs[1].un         = '0;
        vecs[1].up         = {18'd0, 18'd0, 18'h0ABCD, 18'd0, 18'd0};
        vecs[1].exp_new    = {18'd0, 18'd0, 18'h0ABCD, 18'd0, 18'd0};
        vecs[1].exp_down   = '0;
        vecs[1].exp_center = 18'h0ABCD;

        vecs[2].mode       = 2'd2;
        vecs[2].un         = '0;
        vecs[2].up         = '0;
        vecs[2].exp_new    = '0;
        vecs[2].exp_down   = '0;
        vecs[2].exp_center = 18'd0;

        vecs[3].mode       = 2'd2;
        vecs[3].un         = {18'd50, 18'd40, 18'd30, 18'd20, 18'd10};
        vecs[3].up         = {18'd5, 18'd4, 18'd3, 18'd2, 18'd1};
        vecs[3].exp_new    = {18'd35, 18'd76, 18'd57, 18'd38, 18'd19};
        vecs[3].exp_down   = {18'd40, 18'd30, 18'd20, 18'd10, 18'd0};
        vecs[3].exp_center = 18'd57;

        vecs[4].mode       = 2'd0;
        vecs[4].un         = {18'h1FFFF, 18'd0, 18'd0, 18'd0, 18'h3FFFF};
        vecs[4].up         = '0;
        vecs[4].exp_new    = {18'd0, 18'h1FFFF, 18'd0, 18'h3FFFF, 18'd0};
        vecs[4].exp_down   = {18'd0, 18'd0, 18'd0, 18'h3FFFF, 18'd0};
        vecs[4].exp_center = 18'd0;

        for (int i = 0; i < R; i++) begin
            m_un[i] = 18'd0;
            m_up[i] = 18'd0;
        end

        reset = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check18("reset_center", center_out, 18'd0);
        check18("reset_node_u_n", node_u_n, 18'd0);
        check18("reset_node_u_down", node_u_down, 18'd0);

        for (int v = 0; v < N_VEC; v++) begin
            mode = vecs[v].mode;
            for (int i = 0; i < R; i++) init_row(i, vecs[v].un[i], vecs[v].up[i]);
            run_step(0, 0, 1'b0, 18'd0, 18'd0);
            for (int i = 0; i < R; i++)
                check18($sformatf("vec%0d_down%0d", v, i), cap_d[i], vecs[v].exp_down[i]);
            for (int k = 0; k < 5; k++) tick();
            check18($sformatf("vec%0d_center_hold", v), center_out, vecs[v].exp_center);
            run_step(0, 0, 1'b0, 18'd0, 18'd0);
            for (int i = 0; i < R; i++) begin
                check18($sformatf("vec%0d_new_u_n%0d", v, i), cap_n[i], vecs[v].exp_new[i]);
                check18($sformatf("vec%0d_new_u_prev%0d", v, i), cap_p[i], vecs[v].un[i]);
            end
        end

        for (int r = 0; r < 3; r++) begin
            mode = 2'($urandom_range(0, 2));
            for (int i = 0; i < R - 1; i++) init_row(i, 18'($urandom), 18'($urandom));
            run_step(0, 0, 1'b1, 18'($urandom), 18'($urandom));
            run_step(0, 0, 1'b0, 18'd0, 18'd0);
            run_step(0, 0, 1'b0, 18'd0, 18'd0);
        end

        mode = 2'd2;
        init_random();
        run_step(1, 0, 1'b0, 18'd0, 18'd0);
        run_step(0, 0, 1'b0, 18'd0, 18'd0);

        init_random();
        run_step(2, 3, 1'b0, 18'd0, 18'd0);
        init_random();
        run_step(0, 0, 1'b0, 18'd0, 18'd0);
        run_step(0, 0, 1'b0, 18'd0, 18'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/column_sweep_ctrl.md
# column_sweep_ctrl

Sequencing controller that feeds one `column_node` and owns the column's state memory. It holds u_n and u_prev for ROWS nodes in two internal 512x18 M10K-style banks with a 2-cycle read. On each `start` it walks the rows bottom to top and presents u_n, u_prev and the up/down neighbours to the node. It then writes the node result back, so each `start` advances the column by one time step. It sits between the host/initialisation logic and the combinational node datapath, and also exports the centre-row amplitude for audio output.

## Interface
- ROWS, default 30: number of nodes in the column, 2..512.
- CENTER, default 15: row index whose new value is latched to `center_out`, 0..ROWS-1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- init_wr  in  1  initial-condition write strobe; honoured only in IDLE.
- init_addr  in  9  row written by `init_wr`.
- init_u_n  in  18  signed 1.17 value written to the u_n bank.
- init_u_prev  in  18  signed 1.17 value written to the u_prev bank.
- start  in  1  begin one time step; honoured only in IDLE.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- node_u_n, node_u_prev, node_u_up, node_u_down  out  18 each  operands to `column_node`.
- node_out  in  18  `column_node` result (u_next), combinational from the node_* outputs.
- center_out  out  18  u_next of row CENTER from the most recent sweep.

## Operation
- States: IDLE, PRIME, PW1, PW2, RD, W1, W2, CALC, DONE.
- IDLE:
  - `init_wr` writes both banks at `init_addr` in the same cycle.
  - `start` goes to PRIME with row index i = 0.
  - `init_wr` and `start` both high in IDLE: the write is performed and the sweep starts. The write lands before the first read.
- PRIME: issue a read of u_n[0]. PW1/PW2 wait out the 2-cycle latency. At the end of PW2, cur <= u_n[0] and down <= 0. Go to RD.
- RD: issue reads of u_prev[i] and u_n[i+1]. For i = ROWS-1 the u_n read is suppressed and up = 0. W1/W2 wait. At the end of W2, up and prev are registered.
- CALC:
  - Outputs: node_u_n = cur, node_u_prev = prev, node_u_up = up, node_u_down = down.
  - Writes: u_n[i] <= node_out and u_prev[i] <= cur.
  - If i == CENTER, center_out <= node_out.
  - Shifts: down <= cur, cur <= up.
  - If i == ROWS-1, go to DONE; else i <= i+1 and go to RD.
- DONE: `done` = 1 for one cycle, then IDLE.
- Fixed boundaries:
  - row 0 sees node_u_down = 0.
  - row ROWS-1 sees node_u_up = 0.
- The neighbour for row i uses the old u_n[i-1], held in the `down` register, never the freshly written value.
- `start` outside IDLE is ignored (no queuing). `init_wr` outside IDLE is ignored.
- No arithmetic is performed here. Values pass through unmodified as 18-bit signed 1.17.
- node_* outputs are don't-care outside CALC. They are driven 0 in IDLE.
- Reset:
  - state becomes IDLE; busy, done, center_out, node_* and internal registers become 0.
  - Memory contents are not cleared.
  - Reset mid-sweep leaves the banks partially updated; the host must re-initialise.

## Timing
- Bank read: address registered at edge k, data valid after edge k+2.
- Bank write: takes effect at the edge ending CALC or the IDLE write cycle.
- `start` sampled at edge t: busy = 1 from cycle t+1 (PRIME) through the last CALC.
- Sweep length: busy is high for exactly 3 + 4*ROWS cycles. `done` is high in the next cycle with busy = 0.
- Back-to-back steps: the earliest next `start` is sampled in the cycle after DONE. Step period is at least 5 + 4*ROWS cycles.
- center_out updates at the edge ending CALC of row CENTER and holds until the next such edge or reset.

## Test plan
- Zero column: ROWS=30, all banks initialised to 0, real `column_node`. After one step, `done` pulses exactly 124 cycles after `start` (123 busy cycles + DONE), center_out = 0, and all u_n rows read back 0.
- Neighbour wiring with stub node_out = node_u_up + node_u_down, ROWS=4, u_n = {1,2,3,4} (×2^-17), u_prev = 0. Required new u_n = {2,4,6,3}, u_prev = {1,2,3,4}, and the CALC values of node_u_down = {0,1,2,3}.
- Centre capture: stub node_out = node_u_prev, CENTER=2, u_prev[2] = 18'h0ABCD. After the step, center_out = 18'h0ABCD and stays stable through idle cycles.
- Ignored requests: `start` pulsed and `init_wr` to row 0 with 18'h00123 issued mid-sweep. The sweep length is unchanged, exactly one `done` is produced, and row 0 does not hold 18'h00123.
- Reset mid-sweep: assert reset in CALC of row 10. Next cycle busy = 0, done = 0, center_out = 0, state IDLE. A fresh init followed by `start` completes normally.
- Impulse with the real node (rho = 0.125, eta_term = 0.0002): u_n[15] = u_prev[15] = 0.25, all others 0. After one step, rows 14 and 16 are nonzero and equal, rows at distance ≥ 2 from row 15 remain 0, and center_out equals the model value ±1 LSB.
